// File: rtl/digit_pkg.sv
// -----------------------------------------------------------------------------
// digit_pkg
// Shared definitions for the digit sequencing controller:
//   - controller state enumeration
//   - host register addresses and CTRL/STATUS bit positions
//   - default sizes of the input block, result block and result base address
//   - helper that assembles the STATUS register word
// No ports; imported by every file of the block.
// -----------------------------------------------------------------------------
package digit_pkg;

  // Controller phases: waiting, accepting input words, engine busy, result ready
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Default geometry of the shared buffer
  localparam int N_IN_DEF     = 25;
  localparam int N_OUT_DEF    = 10;
  localparam int RES_BASE_DEF = 32;

  // Widths used across the block
  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;
  localparam int MEM_AW = 6;

  // Host register map
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_RES0   = 4'h3;

  // CTRL write bits
  localparam int CTRL_START   = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int CTRL_IRQ_ACK = 2;

  // STATUS read bits; load_count occupies the low CNT_W bits
  localparam int STAT_ERR  = 15;
  localparam int STAT_DONE = 14;
  localparam int STAT_BUSY = 13;

  // Builds the STATUS word from the individual flags and the load counter
  function automatic logic [DATA_W-1:0] packStatus(
    input logic             err,
    input logic             done,
    input logic             busy,
    input logic [CNT_W-1:0] loadCount
  );
    logic [DATA_W-1:0] status;
    status            = '0;
    status[STAT_ERR]  = err;
    status[STAT_DONE] = done;
    status[STAT_BUSY] = busy;
    status[CNT_W-1:0] = loadCount;
    return status;
  endfunction

endpackage

// File: rtl/digit_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// digit_seq_ctrl_if
// Host bus of the digit sequencing controller (Avalon-MM style, read latency 1).
//   chipselect, address[3:0], read, write, writedata[15:0] : host -> controller
//   readdata[15:0], irq                                     : controller -> host
// Modports: master (host side), slave (controller side).
// -----------------------------------------------------------------------------
interface digit_seq_ctrl_if;
  import digit_pkg::*;

  logic              chipselect;
  logic [3:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output chipselect, address, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  chipselect, address, read, write, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/digit_port_mux.sv
// -----------------------------------------------------------------------------
// digit_port_mux
// Combinational owner selection for the two ports of the external shared RAM.
// While the engine owns the buffer it drives both ports; otherwise the host
// side drives the read port (result readback) and write port (input loading).
//   i_block                         : forces every RAM port output to 0
//   i_engOwns                       : engine owns both ports this cycle
//   i_hostRdEn, i_hostResIdx        : host result read, result index
//   i_hostWrEn, i_hostWrAddr/Data   : host input-word write
//   i_engRd, i_engRdAddr            : engine input read
//   i_engWr, i_engWrAddr/Data       : engine result write
//   o_memRa, o_memWa, o_memWe, o_memD : RAM read address / write port
// -----------------------------------------------------------------------------
module digit_port_mux
  import digit_pkg::*;
#(
  parameter int RES_BASE = RES_BASE_DEF
) (
  input  logic              i_block,
  input  logic              i_engOwns,
  input  logic              i_hostRdEn,
  input  logic [3:0]        i_hostResIdx,
  input  logic              i_hostWrEn,
  input  logic [CNT_W-1:0]  i_hostWrAddr,
  input  logic [DATA_W-1:0] i_hostWrData,
  input  logic              i_engRd,
  input  logic [4:0]        i_engRdAddr,
  input  logic              i_engWr,
  input  logic [3:0]        i_engWrAddr,
  input  logic [DATA_W-1:0] i_engWrData,
  output logic [MEM_AW-1:0] o_memRa,
  output logic [MEM_AW-1:0] o_memWa,
  output logic              o_memWe,
  output logic [DATA_W-1:0] o_memD
);

  localparam logic [MEM_AW-1:0] RES_BASE_A = MEM_AW'(RES_BASE);

  // Idle ports are held at zero so an unused cycle never shows a stale address
  always_comb begin
    o_memRa = '0;
    o_memWa = '0;
    o_memWe = 1'b0;
    o_memD  = '0;
    if (!i_block) begin
      if (i_engOwns) begin
        if (i_engRd) begin
          o_memRa = {1'b0, i_engRdAddr};
        end
        if (i_engWr) begin
          o_memWe = 1'b1;
          o_memWa = RES_BASE_A + {2'b00, i_engWrAddr};
          o_memD  = i_engWrData;
        end
      end else begin
        if (i_hostRdEn) begin
          o_memRa = RES_BASE_A + {2'b00, i_hostResIdx};
        end
        if (i_hostWrEn) begin
          o_memWe = 1'b1;
          o_memWa = {1'b0, i_hostWrAddr};
          o_memD  = i_hostWrData;
        end
      end
    end
  end

endmodule

// File: rtl/digit_seq_ctrl.sv
// -----------------------------------------------------------------------------
// digit_seq_ctrl
// Sequences a digit-processing engine over a shared external RAM: the host
// loads N_IN input words, starts the engine, and reads back N_OUT results once
// the engine signals completion.
//   clk, reset                       : clock, synchronous active-high reset
//   host (digit_seq_ctrl_if.slave)   : register bus + irq
//   eng_start / eng_done             : engine start pulse / completion pulse
//   eng_rd, eng_rd_addr, eng_rd_data : engine input-word reads (1-cycle latency)
//   eng_wr, eng_wr_addr, eng_wr_data : engine result writes
//   mem_ra, mem_wa, mem_we, mem_d, mem_q : external two-port RAM
// -----------------------------------------------------------------------------
module digit_seq_ctrl
  import digit_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int N_OUT    = N_OUT_DEF,
  parameter int RES_BASE = RES_BASE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  digit_seq_ctrl_if.slave     host,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic                eng_rd,
  input  logic [4:0]          eng_rd_addr,
  output logic [DATA_W-1:0]   eng_rd_data,
  input  logic                eng_wr,
  input  logic [3:0]          eng_wr_addr,
  input  logic [DATA_W-1:0]   eng_wr_data,
  output logic [MEM_AW-1:0]   mem_ra,
  output logic [MEM_AW-1:0]   mem_wa,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_d,
  input  logic [DATA_W-1:0]   mem_q
);

  localparam logic [CNT_W-1:0] N_IN_CNT = CNT_W'(N_IN);
  localparam logic [3:0]       RES_LAST = 4'(int'(ADDR_RES0) + N_OUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_loadCount;
  logic               r_err;
  logic               r_done;
  logic               r_irq;
  logic               r_engStart;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_readFromRam;
  logic               r_engRdPending;

  logic               w_hostRd;
  logic               w_hostWr;
  logic               w_isResult;
  logic [3:0]         w_resIdx;
  logic               w_engOwns;
  logic               w_hostRamRd;
  logic               w_dataWr;
  logic               w_loadFull;
  logic               w_dataAccept;
  logic               w_ctrlWr;
  logic               w_clear;
  logic               w_start;
  logic               w_irqAck;
  logic [DATA_W-1:0]  w_regReadValue;

  // Bus decode; every host access is qualified by chipselect
  assign w_hostRd     = host.chipselect & host.read;
  assign w_hostWr     = host.chipselect & host.write;
  assign w_isResult   = (host.address >= ADDR_RES0) && (host.address <= RES_LAST);
  assign w_resIdx     = host.address - ADDR_RES0;
  assign w_engOwns    = (r_state == ST_RUN);
  assign w_hostRamRd  = w_hostRd & w_isResult & ~w_engOwns;
  assign w_dataWr     = w_hostWr & (host.address == ADDR_DATA);
  assign w_loadFull   = (r_loadCount == N_IN_CNT);
  assign w_dataAccept = w_dataWr & ~w_loadFull &
                        ((r_state == ST_IDLE) | (r_state == ST_LOAD));
  assign w_ctrlWr     = w_hostWr & (host.address == ADDR_CTRL);
  assign w_clear      = w_ctrlWr & host.writedata[CTRL_CLEAR];
  assign w_start      = w_ctrlWr & host.writedata[CTRL_START] & ~host.writedata[CTRL_CLEAR];
  assign w_irqAck     = w_ctrlWr & host.writedata[CTRL_IRQ_ACK];

  // Register-backed read values; RAM-backed results bypass this path and are
  // taken straight from mem_q in the following cycle to keep read latency 1
  always_comb begin
    w_regReadValue = '0;
    if (host.address == ADDR_STATUS) begin
      w_regReadValue = packStatus(r_err, r_done, w_engOwns, r_loadCount);
    end
  end

  digit_port_mux #(
    .RES_BASE(RES_BASE)
  ) u_portMux (
    .i_block      (reset),
    .i_engOwns    (w_engOwns),
    .i_hostRdEn   (w_hostRamRd),
    .i_hostResIdx (w_resIdx),
    .i_hostWrEn   (w_dataAccept),
    .i_hostWrAddr (r_loadCount),
    .i_hostWrData (host.writedata),
    .i_engRd      (eng_rd),
    .i_engRdAddr  (eng_rd_addr),
    .i_engWr      (eng_wr),
    .i_engWrAddr  (eng_wr_addr),
    .i_engWrData  (eng_wr_data),
    .o_memRa      (mem_ra),
    .o_memWa      (mem_wa),
    .o_memWe      (mem_we),
    .o_memD       (mem_d)
  );

  // Controller FSM with all flags and outputs registered. CLEAR wins over every
  // other event of the same cycle; IRQ_ACK is applied before a coincident
  // eng_done so a fresh completion is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_loadCount    <= '0;
      r_err          <= 1'b0;
      r_done         <= 1'b0;
      r_irq          <= 1'b0;
      r_engStart     <= 1'b0;
      r_readdata     <= '0;
      r_readFromRam  <= 1'b0;
      r_engRdPending <= 1'b0;
    end else begin
      r_engStart     <= 1'b0;
      r_readFromRam  <= w_hostRamRd;
      r_readdata     <= w_hostRd ? w_regReadValue : '0;
      r_engRdPending <= w_engOwns & eng_rd;
      if (w_clear) begin
        r_state     <= ST_IDLE;
        r_loadCount <= '0;
        r_err       <= 1'b0;
        r_done      <= 1'b0;
        r_irq       <= 1'b0;
      end else begin
        if (w_irqAck) begin
          r_irq <= 1'b0;
        end
        unique case (r_state)
          ST_IDLE, ST_LOAD: begin
            if (w_dataWr) begin
              if (w_loadFull) begin
                r_err <= 1'b1;
              end else begin
                r_loadCount <= r_loadCount + 5'd1;
                r_state     <= ST_LOAD;
              end
            end
            if (w_start) begin
              if ((r_state == ST_LOAD) && w_loadFull) begin
                r_state    <= ST_RUN;
                r_engStart <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (w_dataWr || w_start) begin
              r_err <= 1'b1;
            end
            if (eng_done) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_irq   <= 1'b1;
            end
          end
          ST_DONE: begin
            if (w_dataWr || w_start) begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign host.readdata = r_readFromRam ? mem_q : r_readdata;
  assign host.irq      = r_irq;
  assign eng_start     = r_engStart;
  // Engine read data is only meaningful while the engine still owns the RAM
  assign eng_rd_data   = (r_engRdPending && (r_state == ST_RUN)) ? mem_q : '0;

endmodule

// File: tb/tb_digit_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_seq_ctrl
// Self-checking bench for digit_seq_ctrl: random host/engine traffic against a
// behavioural model, a table of register-level vectors, and hand-written
// multi-cycle sequences. Owns a 64x16 registered-read RAM model.
// -----------------------------------------------------------------------------
module tb_digit_seq_ctrl;
  import digit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        eng_start, eng_done, eng_rd, eng_wr;
  logic [4:0]  eng_rd_addr;
  logic [15:0] eng_rd_data;
  logic [3:0]  eng_wr_addr;
  logic [15:0] eng_wr_data;
  logic [5:0]  mem_ra, mem_wa;
  logic        mem_we;
  logic [15:0] mem_d, mem_q;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  digit_seq_ctrl_if host();

  digit_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .host        (host),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_rd      (eng_rd),
    .eng_rd_addr (eng_rd_addr),
    .eng_rd_data (eng_rd_data),
    .eng_wr      (eng_wr),
    .eng_wr_addr (eng_wr_addr),
    .eng_wr_data (eng_wr_data),
    .mem_ra      (mem_ra),
    .mem_wa      (mem_wa),
    .mem_we      (mem_we),
    .mem_d       (mem_d),
    .mem_q       (mem_q)
  );

  // External shared buffer: synchronous write, registered read
  logic [15:0] ram [64] = '{default: 16'hBEEF};
  always @(posedge clk) begin
    if (mem_we) ram[mem_wa] <= mem_d;
    mem_q <= ram[mem_ra];
  end

  // Behavioural model of the controller as seen by host and engine
  int          mCount;
  bit          mRunning, mDone, mErr, mIrq;
  logic [15:0] mRam [64];

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        expStart;
    logic [15:0] expStatus;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%04h, want 0x%04h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0b, want %0b", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    host.chipselect = 1'b0; host.read = 1'b0; host.write = 1'b0;
    host.address = 4'h0;    host.writedata = 16'h0;
    eng_done = 1'b0; eng_rd = 1'b0; eng_wr = 1'b0;
    eng_rd_addr = 5'd0; eng_wr_addr = 4'd0; eng_wr_data = 16'h0;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic wr, input logic rd, input logic [15:0] data);
    host.chipselect = wr | rd;
    host.write      = wr;
    host.read       = rd;
    host.address    = addr;
    host.writedata  = data;
  endtask

  task automatic hostWrite(input logic [3:0] addr, input logic [15:0] data);
    applyStimulus(addr, 1'b1, 1'b0, data);
    tick();
    idleAll();
  endtask

  task automatic hostRead(input logic [3:0] addr, output logic [15:0] data);
    applyStimulus(addr, 1'b0, 1'b1, 16'h0);
    tick();
    data = host.readdata;
    idleAll();
  endtask

  task automatic loadWords(input int n);
    for (int i = 1; i <= n; i++) hostWrite(ADDR_DATA, 16'(i));
  endtask

  task automatic checkStatus(input string name, input logic [15:0] expected);
    logic [15:0] v;
    hostRead(ADDR_STATUS, v);
    checkOutput(name, v, expected);
  endtask

  function automatic logic [15:0] modelRead(input logic [3:0] a);
    if (a == ADDR_STATUS)
      return {mErr, mDone, mRunning, 8'h00, 5'(mCount)};
    if (a >= 4'd3 && a <= 4'd12)
      return mRunning ? 16'h0000 : mRam[RES_BASE_DEF + int'(a) - 3];
    return 16'h0000;
  endfunction

  task automatic modelStep(input bit wr, input logic [3:0] a, input logic [15:0] d,
                           input bit eWr, input logic [3:0] eWa, input logic [15:0] eWd,
                           input bit eDone, output bit started);
    bit preRun  = mRunning;
    bit cleared = 1'b0;
    started = 1'b0;
    if (preRun && eWr) mRam[RES_BASE_DEF + int'(eWa)] = eWd;
    if (wr && a == ADDR_DATA) begin
      if (mRunning || mDone || mCount == N_IN_DEF) mErr = 1'b1;
      else begin
        mRam[mCount] = d;
        mCount++;
      end
    end
    if (wr && a == ADDR_CTRL) begin
      if (d[CTRL_CLEAR]) begin
        mCount = 0; mErr = 0; mDone = 0; mIrq = 0; mRunning = 0; cleared = 1'b1;
      end else begin
        if (d[CTRL_IRQ_ACK]) mIrq = 1'b0;
        if (d[CTRL_START]) begin
          if (!mRunning && !mDone && mCount == N_IN_DEF) begin
            mRunning = 1'b1;
            started  = 1'b1;
          end else mErr = 1'b1;
        end
      end
    end
    if (eDone && preRun && !cleared) begin
      mRunning = 1'b0; mDone = 1'b1; mIrq = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] snap;

    idleAll();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset readdata", host.readdata, 16'h0000);
    checkFlag("reset irq", host.irq, 1'b0);
    checkFlag("reset eng_start", eng_start, 1'b0);
    checkFlag("reset mem_we", mem_we, 1'b0);
    checkOutput("reset mem_ra", 16'(mem_ra), 16'h0000);
    checkOutput("reset eng_rd_data", eng_rd_data, 16'h0000);
    reset = 1'b0;
    checkStatus("reset status", 16'h0000);

    // ---------------- randomized traffic against the model ----------------
    mCount = 0; mRunning = 0; mDone = 0; mErr = 0; mIrq = 0;
    for (int i = 0; i < 64; i++) mRam[i] = 16'hBEEF;
    for (int s = 0; s < 2500; s++) begin
      int          kind;
      logic [3:0]  a;
      logic [15:0] d, eWd, expRd, expEngRd, engRdVal;
      logic        doWr, doRd, eWr, eRd, eDone;
      logic [3:0]  eWa;
      logic [4:0]  eRa;
      bit          preRun, startNow;
      kind = $urandom_range(0, 99);
      doWr = 1'b0; doRd = 1'b0; a = 4'h0; d = 16'($urandom);
      if (kind < 45) begin
        doWr = 1'b1; a = ADDR_DATA;
      end else if (kind < 52) begin
        doWr = 1'b1; a = ADDR_CTRL;
        d[CTRL_CLEAR]   = ($urandom_range(0, 99) < (mDone ? 50 : 4));
        d[CTRL_START]   = 1'($urandom_range(0, 1));
        d[CTRL_IRQ_ACK] = ($urandom_range(0, 3) == 0);
      end else if (kind < 65) begin
        doRd = 1'b1; a = ADDR_STATUS;
      end else if (kind < 80) begin
        doRd = 1'b1; a = 4'(3 + $urandom_range(0, 9));
      end else if (kind < 90) begin
        a    = 4'($urandom_range(0, 15));
        doRd = 1'($urandom_range(0, 1));
        doWr = !doRd && (a >= 4'hD);
      end
      eWr   = ($urandom_range(0, 4) == 0);
      eRd   = ($urandom_range(0, 4) == 0);
      eDone = ($urandom_range(0, 29) == 0);
      eWa   = 4'($urandom_range(0, 9));
      eRa   = 5'($urandom_range(0, 24));
      eWd   = 16'($urandom);

      expRd    = doRd ? modelRead(a) : 16'h0000;
      preRun   = mRunning;
      engRdVal = mRam[eRa];
      modelStep(doWr, a, d, eWr, eWa, eWd, eDone, startNow);
      expEngRd = (preRun && eRd && mRunning) ? engRdVal : 16'h0000;

      applyStimulus(a, doWr, doRd, d);
      eng_wr = eWr; eng_wr_addr = eWa; eng_wr_data = eWd;
      eng_rd = eRd; eng_rd_addr = eRa; eng_done = eDone;
      tick();
      idleAll();
      checkOutput("rand readdata", host.readdata, expRd);
      checkOutput("rand eng_rd_data", eng_rd_data, expEngRd);
      checkFlag("rand eng_start", eng_start, startNow);
      checkFlag("rand irq", host.irq, mIrq);
    end
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("rand ram[%0d]", i), ram[i], mRam[i]);

    // ---------------- table-driven register vectors ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 24; i++) vecs.push_back('{ADDR_DATA, 16'(i), 1'b0, 16'(i)});
    vecs.push_back('{ADDR_CTRL, 16'h0001, 1'b0, 16'h8018});
    vecs.push_back('{ADDR_CTRL, 16'h0002, 1'b0, 16'h0000});
    for (int i = 1; i <= 25; i++) vecs.push_back('{ADDR_DATA, 16'(i), 1'b0, 16'(i)});
    vecs.push_back('{ADDR_DATA, 16'h001A, 1'b0, 16'h8019});
    vecs.push_back('{ADDR_CTRL, 16'h0002, 1'b0, 16'h0000});
    for (int i = 1; i <= 25; i++) vecs.push_back('{ADDR_DATA, 16'(i), 1'b0, 16'(i)});
    vecs.push_back('{ADDR_CTRL, 16'h0001, 1'b1, 16'h2019});

    snap = ram[25];
    foreach (vecs[i]) begin
      hostWrite(vecs[i].addr, vecs[i].wdata);
      checkFlag($sformatf("vec%0d eng_start", i), eng_start, vecs[i].expStart);
      checkStatus($sformatf("vec%0d status", i), vecs[i].expStatus);
      checkFlag($sformatf("vec%0d eng_start drop", i), eng_start, 1'b0);
    end
    checkOutput("ram[25] kept", ram[25], snap);
    for (int i = 0; i < 25; i++)
      checkOutput($sformatf("loaded ram[%0d]", i), ram[i], 16'(i + 1));

    // ---------------- engine session in RUN ----------------
    eng_rd = 1'b1; eng_rd_addr = 5'd5;
    tick();
    idleAll();
    checkOutput("eng_rd_data word5", eng_rd_data, 16'h0006);

    applyStimulus(4'h6, 1'b0, 1'b1, 16'h0);
    #1;
    checkOutput("run result mem_ra", 16'(mem_ra), 16'h0000);
    tick();
    checkOutput("run result read", host.readdata, 16'h0000);
    idleAll();

    eng_wr = 1'b1; eng_wr_addr = 4'd3; eng_wr_data = 16'h00AB;
    tick();
    idleAll();
    checkOutput("ram[35] eng write", ram[35], 16'h00AB);

    eng_done = 1'b1;
    tick();
    idleAll();
    checkFlag("irq after done", host.irq, 1'b1);
    checkStatus("status done", 16'h4019);
    hostRead(4'h6, rd);
    checkOutput("result3 read", rd, 16'h00AB);

    snap = ram[36];
    eng_wr = 1'b1; eng_wr_addr = 4'd4; eng_wr_data = 16'h7777;
    eng_rd = 1'b1; eng_rd_addr = 5'd2;
    tick();
    idleAll();
    checkOutput("ram[36] ignored", ram[36], snap);
    checkOutput("eng_rd_data outside run", eng_rd_data, 16'h0000);

    hostWrite(ADDR_CTRL, 16'h0004);
    checkFlag("irq after ack", host.irq, 1'b0);
    checkStatus("done persists", 16'h4019);
    hostWrite(ADDR_CTRL, 16'h0001);
    checkStatus("start in done", 16'hC019);
    hostWrite(ADDR_CTRL, 16'h0002);
    checkStatus("clear from done", 16'h0000);

    // ---------------- CLEAR mid-RUN with coincident engine write ----------------
    loadWords(25);
    hostWrite(ADDR_CTRL, 16'h0001);
    checkFlag("second start", eng_start, 1'b1);
    applyStimulus(ADDR_CTRL, 1'b1, 1'b0, 16'h0002);
    eng_wr = 1'b1; eng_wr_addr = 4'd7; eng_wr_data = 16'h1234;
    tick();
    idleAll();
    checkOutput("ram[39] clear write", ram[39], 16'h1234);
    checkStatus("status after clear", 16'h0000);
    eng_done = 1'b1;
    tick();
    idleAll();
    checkFlag("late done irq", host.irq, 1'b0);
    checkStatus("late done status", 16'h0000);

    // ---------------- reset during RUN ----------------
    loadWords(25);
    hostWrite(ADDR_CTRL, 16'h0001);
    eng_wr = 1'b1; eng_wr_addr = 4'd1; eng_wr_data = 16'h5555;
    tick();
    idleAll();
    snap = ram[34];
    reset = 1'b1;
    eng_wr = 1'b1; eng_wr_addr = 4'd2; eng_wr_data = 16'h9999;
    eng_rd = 1'b1; eng_rd_addr = 5'd3;
    applyStimulus(ADDR_DATA, 1'b1, 1'b0, 16'h4444);
    tick();
    reset = 1'b0;
    idleAll();
    checkOutput("rst readdata", host.readdata, 16'h0000);
    checkFlag("rst irq", host.irq, 1'b0);
    checkFlag("rst eng_start", eng_start, 1'b0);
    checkOutput("rst eng_rd_data", eng_rd_data, 16'h0000);
    checkFlag("rst mem_we", mem_we, 1'b0);
    checkOutput("rst mem_ra", 16'(mem_ra), 16'h0000);
    checkOutput("rst mem_wa", 16'(mem_wa), 16'h0000);
    checkOutput("rst mem_d", mem_d, 16'h0000);
    checkOutput("ram[34] blocked", ram[34], snap);
    checkStatus("status after reset", 16'h0000);
    hostRead(4'h4, rd);
    checkOutput("result1 kept", rd, 16'h5555);
    hostRead(4'h6, rd);
    checkOutput("result3 kept", rd, 16'h00AB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
